multi_cycle_control_unit: RTL and testbench

Sequential, parametrised control unit for the multi-cycle datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the register-file write enable and the 2-bit ALU op select. It also handles the instruction/data memory handshakes and counts retired instructions. It sits between the instruction register and the datapath (register file, ALU, data memory port).

---
 rtl/multi_cycle_control_unit.sv | 110 +++++++++++
 tb/tb_multi_cycle_control_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control_unit.sv
// multi_cycle_control_unit: sequences instructions through fetch/decode/execute/memory/writeback for a multi-cycle datapath
//   in_clk, in_rst_n      : clock (rising edge), asynchronous active-low reset
//   in_run                : start/resume, sampled only in IDLE
//   in_op_code            : opcode from the instruction register, valid in DECODE
//   in_imem_ready         : instruction word available (FETCH handshake)
//   in_dmem_ack           : data memory access complete (MEM handshake)
//   out_imem_req, out_ir_ld, out_pc_en                 : fetch-side strobes
//   out_reg_file_wr_en, out_alu_op_sel, out_wb_sel     : datapath controls
//   out_dmem_rd, out_dmem_wr                           : data memory requests
//   out_halted, out_illegal, out_mem_err               : status
//   out_instr_count                                    : retired-instruction count (wraps)
module multi_cycle_control_unit #(
    parameter int OPCODE_W    = 5,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                in_clk,
    input  logic                in_rst_n,
    input  logic                in_run,
    input  logic [OPCODE_W-1:0] in_op_code,
    input  logic                in_imem_ready,
    input  logic                in_dmem_ack,
    output logic                out_imem_req,
    output logic                out_ir_ld,
    output logic                out_pc_en,
    output logic                out_reg_file_wr_en,
    output logic [1:0]          out_alu_op_sel,
    output logic                out_wb_sel,
    output logic                out_dmem_rd,
    output logic                out_dmem_wr,
    output logic                out_halted,
    output logic                out_illegal,
    output logic                out_mem_err,
    output logic [CNT_W-1:0]    out_instr_count
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_OR    = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(7);
    state_t              r_state;
    logic [OPCODE_W-1:0] r_op;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_mem_err;
    logic [CNT_W-1:0]    r_count;
    logic                w_is_alu;
    logic                w_is_mem;
    logic                w_load;
    logic                w_wait_last;
    logic                w_retire;
    assign w_is_alu    = in_op_code >= OP_ADD && in_op_code <= OP_OR;
    assign w_is_mem    = in_op_code == OP_LOAD || in_op_code == OP_STORE;
    assign w_load      = r_op == OP_LOAD;
    // r_wait counts earlier ack-free MEM cycles, so the current one is the last allowed
    assign w_wait_last = r_wait == WAIT_W'(MEM_TIMEOUT - 1);
    // NOP, HALT and illegal opcodes retire at decode; LOAD retires on leaving WB
    assign w_retire = r_state == S_EXEC || r_state == S_WB ||
                      (r_state == S_MEM && in_dmem_ack && !w_load) ||
                      (r_state == S_DECODE && !w_is_alu && !w_is_mem);
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_wait    <= '0;
            r_mem_err <= 1'b0;
            r_count   <= '0;
        end else begin
            if (w_retire) r_count <= r_count + 1'b1;
            case (r_state)
                S_IDLE: if (in_run) begin
                    r_state   <= S_FETCH;
                    r_mem_err <= 1'b0;
                end
                S_FETCH: if (in_imem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    r_op    <= in_op_code;
                    r_wait  <= '0;
                    r_state <= w_is_alu ? S_EXEC :
                               w_is_mem ? S_MEM :
                               in_op_code == OP_HALT ? S_IDLE : S_FETCH;
                end
                S_EXEC, S_WB: r_state <= S_FETCH;
                S_MEM: begin
                    // an ack in the final allowed cycle still completes normally
                    if (in_dmem_ack) r_state <= w_load ? S_WB : S_FETCH;
                    else if (w_wait_last) begin
                        r_state   <= S_IDLE;
                        r_mem_err <= 1'b1;
                    end else r_wait <= r_wait + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign out_halted         = r_state == S_IDLE;
    assign out_imem_req       = r_state == S_FETCH;
    assign out_ir_ld          = r_state == S_FETCH && in_imem_ready;
    assign out_pc_en          = r_state == S_DECODE;
    assign out_illegal        = r_state == S_DECODE && in_op_code > OP_HALT;
    assign out_reg_file_wr_en = r_state == S_EXEC || r_state == S_WB;
    // ADD..OR are 1..4, so the low two bits minus one give 0..3
    assign out_alu_op_sel     = r_state == S_EXEC ? r_op[1:0] - 2'd1 : 2'd0;
    assign out_wb_sel         = r_state == S_WB;
    assign out_dmem_rd        = r_state == S_MEM && w_load;
    assign out_dmem_wr        = r_state == S_MEM && r_op == OP_STORE;
    assign out_mem_err        = r_mem_err;
    assign out_instr_count    = r_count;
endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// tb_multi_cycle_control_unit: directed-vector scoreboard bench for multi_cycle_control_unit
module tb_multi_cycle_control_unit;
    localparam logic [11:0] E_IDLE  = 12'h004;
    localparam logic [11:0] E_FWAIT = 12'h800;
    localparam logic [11:0] E_FRDY  = 12'hC00;
    localparam logic [11:0] E_DEC   = 12'h200;
    localparam logic [11:0] E_ILL   = 12'h202;
    localparam logic [11:0] E_EXEC  = 12'h100;
    localparam logic [11:0] E_MRD   = 12'h010;
    localparam logic [11:0] E_MWR   = 12'h008;
    localparam logic [11:0] E_WB    = 12'h120;
    localparam logic [11:0] E_ERR   = 12'h001;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [4:0] op;
    logic       rdy;
    logic       ack;
    logic       imem_req, ir_ld, pc_en, wr_en, wb_sel, dmem_rd, dmem_wr, halted, illegal, mem_err;
    logic [1:0] alu_sel;
    logic [3:0] cnt;
    logic [3:0] ecnt;
    logic [15:0] q_exp[$];
    string       q_nm[$];
    int          n_chk = 0;
    int          n_fail = 0;
    multi_cycle_control_unit #(.OPCODE_W(5), .CNT_W(4), .MEM_TIMEOUT(16)) dut (
        .in_clk(clk),
        .in_rst_n(rst_n),
        .in_run(run),
        .in_op_code(op),
        .in_imem_ready(rdy),
        .in_dmem_ack(ack),
        .out_imem_req(imem_req),
        .out_ir_ld(ir_ld),
        .out_pc_en(pc_en),
        .out_reg_file_wr_en(wr_en),
        .out_alu_op_sel(alu_sel),
        .out_wb_sel(wb_sel),
        .out_dmem_rd(dmem_rd),
        .out_dmem_wr(dmem_wr),
        .out_halted(halted),
        .out_illegal(illegal),
        .out_mem_err(mem_err),
        .out_instr_count(cnt)
    );
    always #5 clk = ~clk;
    logic [15:0] obs;
    assign obs = {imem_req, ir_ld, pc_en, wr_en, alu_sel, wb_sel, dmem_rd, dmem_wr, halted, illegal, mem_err, cnt};
    logic [15:0] m_exp;
    string       m_nm;
    always @(negedge clk) begin
        if (q_exp.size() != 0) begin
            m_exp = q_exp.pop_front();
            m_nm  = q_nm.pop_front();
            n_chk++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", m_nm, obs, m_exp);
            end
        end
    end
    task automatic cyc(input string nm, input logic i_run, input logic [4:0] i_op,
                       input logic i_rdy, input logic i_ack, input logic [11:0] eo);
        @(posedge clk);
        #1;
        run = i_run;
        op  = i_op;
        rdy = i_rdy;
        ack = i_ack;
        q_exp.push_back({eo, ecnt});
        q_nm.push_back(nm);
    endtask
    task automatic alu(input logic [4:0] o);
        cyc($sformatf("alu%0d_fetch", o), 0, o, 1, 0, E_FRDY);
        cyc($sformatf("alu%0d_dec", o), 0, o, 0, 0, E_DEC);
        cyc($sformatf("alu%0d_exec", o), 0, 0, 0, 0, E_EXEC | 12'((o - 5'd1) & 5'd3) << 6);
        ecnt++;
    endtask
    initial begin
        rst_n = 1'b0;
        run = 0; op = 0; rdy = 0; ack = 0;
        ecnt = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc("reset_idle", 0, 0, 0, 0, E_IDLE);
        cyc("run_idle", 1, 0, 0, 0, E_IDLE);
        for (int o = 1; o <= 4; o++) alu(5'(o));
        cyc("ld_fwait", 0, 5, 0, 0, E_FWAIT);
        cyc("ld_fetch", 0, 5, 1, 0, E_FRDY);
        cyc("ld_dec", 0, 5, 0, 0, E_DEC);
        for (int i = 0; i < 3; i++) cyc("ld_mem_wait", 0, 0, 0, 0, E_MRD);
        cyc("ld_mem_ack", 0, 0, 0, 1, E_MRD);
        cyc("ld_wb", 0, 0, 0, 1, E_WB);
        ecnt++;
        cyc("st_fetch", 0, 6, 1, 0, E_FRDY);
        cyc("st_dec", 0, 6, 0, 0, E_DEC);
        cyc("st_ack", 0, 0, 0, 1, E_MWR);
        ecnt++;
        cyc("nop_fetch", 0, 0, 1, 0, E_FRDY);
        cyc("nop_dec", 0, 0, 0, 0, E_DEC);
        ecnt++;
        cyc("sto_fetch", 0, 6, 1, 0, E_FRDY);
        cyc("sto_dec", 0, 6, 0, 0, E_DEC);
        for (int i = 0; i < 16; i++) cyc("sto_wait", 0, 0, 0, 0, E_MWR);
        cyc("sto_idle_err", 1, 0, 0, 0, E_IDLE | E_ERR);
        cyc("err_clr_fetch", 0, 9, 1, 0, E_FRDY);
        cyc("ill_dec", 0, 9, 0, 0, E_ILL);
        ecnt++;
        cyc("halt_fetch", 0, 7, 1, 0, E_FRDY);
        cyc("halt_dec", 1, 7, 0, 0, E_DEC);
        ecnt++;
        cyc("halt_idle", 1, 0, 0, 0, E_IDLE);
        cyc("stl_fetch", 0, 6, 1, 0, E_FRDY);
        cyc("stl_dec", 0, 6, 0, 0, E_DEC);
        for (int i = 0; i < 15; i++) cyc("stl_wait", 0, 0, 0, 0, E_MWR);
        cyc("stl_last_ack", 0, 0, 0, 1, E_MWR);
        ecnt++;
        cyc("stl_no_err", 0, 0, 0, 0, E_FWAIT);
        for (int i = 0; i < 8; i++) begin
            cyc("wrap_fetch", 0, 0, 1, 0, E_FRDY);
            cyc("wrap_dec", 0, 0, 0, 0, E_DEC);
            ecnt++;
        end
        cyc("rst_fetch", 0, 5, 1, 0, E_FRDY);
        cyc("rst_dec", 0, 5, 0, 0, E_DEC);
        cyc("rst_mem", 0, 0, 0, 0, E_MRD);
        @(posedge clk);
        #2 rst_n = 1'b0;
        ecnt = 0;
        q_exp.push_back({E_IDLE, ecnt});
        q_nm.push_back("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc("post_rst", 0, 0, 0, 0, E_IDLE);
        @(negedge clk);
        #1;
        n_chk++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q_exp.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
